// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule generator, one W_t per accepted cycle
module sha256_msg_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'd63;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic        load;
  logic        xfer;
  logic        last_xfer;
  logic [31:0] w_new;

  // small sigma functions; rotates written as concatenations so no shift widths are involved
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // the window holds W_t..W_t+15, so the word entering at the top is W_t+16
  assign w_new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];

  // start is only looked at in IDLE; a transfer needs an active RUN cycle with the consumer ready
  assign load      = (state == S_IDLE) && start;
  assign xfer      = (state == S_RUN) && w_ready;
  assign last_xfer = xfer && (w_idx == LAST_IDX);

  // outputs decode directly from state so w_out is forced to zero outside RUN
  assign w_valid = (state == S_RUN);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign w_out   = w_valid ? win[0] : 32'd0;

  // next-state logic: DONE lasts one cycle and always falls back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (last_xfer) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // sliding window: parallel load at start, shift-and-append on each transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        win[k] <= 32'd0;
      end
    end else if (load) begin
      for (int k = 0; k < 16; k++) begin
        win[k] <= block_in[511 - 32*k -: 32];
      end
    end else if (xfer) begin
      for (int k = 0; k < 15; k++) begin
        win[k] <= win[k+1];
      end
      win[15] <= w_new;
    end
  end

  // word index; parks at 63 on the final transfer instead of wrapping to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx <= 6'd0;
    end else if (load) begin
      w_idx <= 6'd0;
    end else if (xfer && !last_xfer) begin
      w_idx <= w_idx + 6'd1;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - self-checking bench for sha256_msg_sched
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [511:0] block_in;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_valid;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got   [64];

  typedef struct {
    logic [511:0] blk;
    int           mode;       // 0: ready always, 1: ready 1,0,0 pattern, 2: random ready
    bit           restart10;  // pulse start with another block at t=10
    bit           has_const;
    logic [31:0]  w0, w15, w16, w17;
  } vec_t;

  vec_t vecs [7];

  sha256_msg_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .block_in (block_in),
    .w_ready  (w_ready),
    .w_out    (w_out),
    .w_idx    (w_idx),
    .w_valid  (w_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // reference schedule from the textbook recurrence over a full 64-entry array
  task automatic build_model(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        exp_w[t] = blk[511 - 32*t -: 32];
      end else begin
        s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
        s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
        exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
      end
    end
  endtask

  // runs one schedule starting at the current falling edge; ends on the IDLE falling edge after DONE
  task automatic run_sched(input logic [511:0] blk, input int mode, input bit restart10,
                           input int abort_at, input string tag);
    int   t   = 0;
    int   cyc = 0;
    logic rdy;
    chk($sformatf("%s idle_busy", tag), {31'd0, busy}, 32'd0);
    build_model(blk);
    block_in = blk;
    start    = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (t < 64 && cyc < 1000) begin
      if (abort_at == t) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("%s rst_valid", tag), {31'd0, w_valid}, 32'd0);
        chk($sformatf("%s rst_busy", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s rst_done", tag), {31'd0, done}, 32'd0);
        chk($sformatf("%s rst_wout", tag), w_out, 32'd0);
        chk($sformatf("%s rst_idx", tag), {26'd0, w_idx}, 32'd0);
        start   = 1'b0;
        w_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("%s rst_done2", tag), {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        return;
      end
      chk($sformatf("%s valid t=%0d", tag, t), {31'd0, w_valid}, 32'd1);
      chk($sformatf("%s idx t=%0d", tag, t), {26'd0, w_idx}, t);
      chk($sformatf("%s w t=%0d", tag, t), w_out, exp_w[t]);
      chk($sformatf("%s run_done t=%0d", tag, t), {31'd0, done}, 32'd0);
      chk($sformatf("%s run_busy t=%0d", tag, t), {31'd0, busy}, 32'd1);
      got[t]   = w_out;
      block_in = ~blk;
      start    = (restart10 && t == 10) ? 1'b1 : ($urandom_range(0, 3) == 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 3) == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      w_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) t++;
    end
    start   = 1'b0;
    w_ready = 1'b0;
    chk($sformatf("%s word_count", tag), t, 32'd64);
    chk($sformatf("%s done_pulse", tag), {31'd0, done}, 32'd1);
    chk($sformatf("%s done_busy", tag), {31'd0, busy}, 32'd1);
    chk($sformatf("%s done_valid", tag), {31'd0, w_valid}, 32'd0);
    chk($sformatf("%s done_wout", tag), w_out, 32'd0);
    chk($sformatf("%s done_idx", tag), {26'd0, w_idx}, 32'd63);
    if (mode == 0) chk($sformatf("%s done_latency", tag), cyc, 32'd65);
    @(negedge clk);
    chk($sformatf("%s post_done", tag), {31'd0, done}, 32'd0);
    chk($sformatf("%s post_busy", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s post_valid", tag), {31'd0, w_valid}, 32'd0);
  endtask

  initial begin
    logic [511:0] abc_blk;
    logic [511:0] rnd_blk;
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};

    vecs[0] = '{abc_blk, 0, 1'b0, 1'b1, 32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000};
    vecs[1] = '{abc_blk, 0, 1'b0, 1'b1, 32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000};
    vecs[2] = '{512'd0,  0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{abc_blk, 1, 1'b0, 1'b1, 32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000};
    vecs[4] = '{abc_blk, 0, 1'b1, 1'b1, 32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000};
    for (int v = 5; v < 7; v++) begin
      for (int k = 0; k < 16; k++) rnd_blk[511 - 32*k -: 32] = $urandom();
      vecs[v] = '{rnd_blk, 2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    end

    rst_n    = 1'b0;
    start    = 1'b0;
    w_ready  = 1'b0;
    block_in = '0;
    repeat (2) @(negedge clk);
    chk("reset valid", {31'd0, w_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset wout", w_out, 32'd0);
    chk("reset idx", {26'd0, w_idx}, 32'd0);
    rst_n = 1'b1;

    // consecutive entries start on the IDLE cycle right after DONE, giving back-to-back blocks
    for (int v = 0; v < 7; v++) begin
      run_sched(vecs[v].blk, vecs[v].mode, vecs[v].restart10, -1, $sformatf("vec%0d", v));
      if (vecs[v].has_const) begin
        chk($sformatf("vec%0d W0", v), got[0], vecs[v].w0);
        chk($sformatf("vec%0d W15", v), got[15], vecs[v].w15);
        chk($sformatf("vec%0d W16", v), got[16], vecs[v].w16);
        chk($sformatf("vec%0d W17", v), got[17], vecs[v].w17);
      end
    end

    for (int k = 0; k < 16; k++) rnd_blk[511 - 32*k -: 32] = $urandom();
    run_sched(rnd_blk, 0, 1'b0, 30, "abort");
    run_sched(abc_blk, 0, 1'b0, -1, "post_abort");
    chk("post_abort W0", got[0], 32'h61626380);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
